// File: rtl/button_event_scheduler.sv
// -----------------------------------------------------------------------------
// button_event_scheduler
//
// Debounces N raw switch inputs and turns each accepted level change into a
// press/release event. Events wait in a one-deep per-button pending store and
// are serialised onto a single valid/ready port by a round-robin arbiter.
//
// Debounce: a shared prescaler produces a one-cycle tick every TICK_DIV
// clocks. A button's debounced level flips only after STABLE_TICKS
// consecutive ticks on which the synchronised input disagreed with it; any
// agreement, even for one cycle, restarts the count.
//
// Optional long-press (macro BUTTON_EVENT_SCHEDULER_LONGPRESS_EN): a per-button
// hold counter counts ticks while the debounced level is high and posts a
// single long-press event when it reaches LONG_TICKS. Without the macro no hold
// counters exist, LONG_TICKS is ignored and ev_type never reads 2'b10.
//
// Ports:
//   CLK       system clock, rising edge
//   RST_N     asynchronous active-low reset
//   sw_in     raw asynchronous switch levels [N]
//   state     debounced level per button [N]
//   ev_valid  event available
//   ev_ready  consumer ready
//   ev_id     button index of the presented event [ID_W]
//   ev_type   00 release, 01 press, 10 long press
//   ev_ovf    one-cycle pulse: a pending event was overwritten by a newer one
//
// Handshake: an event transfers on a rising CLK edge where ev_valid and
// ev_ready are both high. While ev_valid is high and ev_ready is low, ev_id and
// ev_type hold. The output register reloads whenever it is empty or its event
// is being taken, so back-to-back acceptance yields one event per cycle.
// -----------------------------------------------------------------------------
module button_event_scheduler #(
  parameter int N            = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8,
  parameter int LONG_TICKS   = 100,
  parameter int ID_W         = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N-1:0]    sw_in,
  output logic [N-1:0]    state,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [ID_W-1:0] ev_id,
  output logic [1:0]      ev_type,
  output logic            ev_ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

  logic [N-1:0]    sync1;
  logic [N-1:0]    s;
  logic [PW-1:0]   pcnt;
  logic            tick;
  logic [CW-1:0]   cnt [N];
  logic [N-1:0]    toggle;

  logic [N-1:0]    post_v;
  logic [1:0]      post_t [N];
  logic [N-1:0]    pend_v;
  logic [1:0]      pend_t [N];
  logic [N-1:0]    ovf_vec;

  logic [ID_W-1:0] rr;
  logic            load;
  logic            gnt_v;
  logic            grant;
  logic [ID_W-1:0] gnt_idx;
  logic [1:0]      gnt_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser and shared tick prescaler
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      s     <= '0;
      pcnt  <= '0;
    end else begin
      sync1 <= sw_in;
      s     <= sync1;
      pcnt  <= tick ? '0 : pcnt + PW'(1);
    end
  end

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  // ---------------------------------------------------------------------------
  // Per-button debounce
  // ---------------------------------------------------------------------------
  always_comb begin
    toggle = '0;
    for (int i = 0; i < N; i++) begin
      toggle[i] = (s[i] != state[i]) && tick && (cnt[i] == CW'(STABLE_TICKS - 1));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s[i] == state[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (toggle[i]) begin
            state[i] <= ~state[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event posting (level change, optionally long press)
  // ---------------------------------------------------------------------------
`ifdef BUTTON_EVENT_SCHEDULER_LONGPRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);

  logic [HW-1:0] hcnt [N];
  logic [N-1:0]  long_post;

  // A release on the same tick as the long-press threshold wins: the button is
  // no longer held, so only the release is reported.
  always_comb begin
    long_post = '0;
    for (int i = 0; i < N; i++) begin
      long_post[i] = state[i] && tick && !toggle[i] &&
                     (hcnt[i] == HW'(LONG_TICKS - 1));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N; i++) hcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!state[i] || toggle[i]) begin
          hcnt[i] <= '0;
        end else if (tick && (hcnt[i] < HW'(LONG_TICKS))) begin
          hcnt[i] <= hcnt[i] + HW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      post_v[i] = toggle[i] | long_post[i];
      post_t[i] = toggle[i] ? {1'b0, ~state[i]} : 2'b10;
    end
  end
`else
  logic unused_long_ticks;
  assign unused_long_ticks = (LONG_TICKS != 0);

  // The event type is the level the button is about to take.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      post_v[i] = toggle[i];
      post_t[i] = {1'b0, ~state[i]};
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: search rr, rr+1, ... (mod N) over the pending store
  // ---------------------------------------------------------------------------
  assign load = !ev_valid || ev_ready;

  always_comb begin
    int j;
    j       = 0;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    gnt_t   = 2'b00;
    for (int k = 0; k < N; k++) begin
      j = int'(rr) + k;
      if (j >= N) j = j - N;
      if (!gnt_v && pend_v[j]) begin
        gnt_v   = 1'b1;
        gnt_idx = ID_W'(j);
        gnt_t   = pend_t[j];
      end
    end
  end

  assign grant = load && gnt_v;

  // An overwrite is only lost data if the older event is not leaving this
  // cycle through the arbiter.
  always_comb begin
    ovf_vec = '0;
    for (int i = 0; i < N; i++) begin
      ovf_vec[i] = post_v[i] && pend_v[i] && !(grant && (gnt_idx == ID_W'(i)));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_v <= '0;
      for (int i = 0; i < N; i++) pend_t[i] <= 2'b00;
      ev_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (post_v[i]) begin
          pend_v[i] <= 1'b1;
          pend_t[i] <= post_t[i];
        end else if (grant && (gnt_idx == ID_W'(i))) begin
          pend_v[i] <= 1'b0;
        end
      end
      ev_ovf <= |ovf_vec;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_type  <= 2'b00;
      rr       <= '0;
    end else if (load) begin
      if (gnt_v) begin
        ev_valid <= 1'b1;
        ev_id    <= gnt_idx;
        ev_type  <= gnt_t;
        rr       <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + ID_W'(1);
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for button_event_scheduler (N=4, TICK_DIV=4, STABLE_TICKS=3).
// Expected events are queued when a switch is driven and compared in order as
// the DUT hands them over on the valid/ready port.
// -----------------------------------------------------------------------------
module tb_button_event_scheduler;

  localparam int N            = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LONG_TICKS   = 5;
  localparam int ID_W         = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [N-1:0]    sw_in = '0;
  logic            ev_ready = 1'b1;
  logic [N-1:0]    state;
  logic            ev_valid;
  logic [ID_W-1:0] ev_id;
  logic [1:0]      ev_type;
  logic            ev_ovf;

  always #5 CLK = ~CLK;

  button_event_scheduler #(
    .N(N), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS),
    .LONG_TICKS(LONG_TICKS), .ID_W(ID_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .sw_in(sw_in), .state(state),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id),
    .ev_type(ev_type), .ev_ovf(ev_ovf)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         checks    = 0;
  int         failures  = 0;
  int         ovf_cnt   = 0;
  bit         long_mode = 1'b0;
  logic [3:0] exp_q[$];   // {id, type}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    bit         skip;
    logic [3:0] e;
    skip = 1'b0;
    e    = '0;
    if (RST_N) begin
      if (ev_ovf) ovf_cnt++;
      if (ev_valid && ev_ready) begin
`ifdef BUTTON_EVENT_SCHEDULER_LONGPRESS_EN
        skip = (ev_type == 2'b10) && !long_mode;
`endif
        if (!skip) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual id=%0d type=%0d required=none", ev_id, ev_type);
          end else begin
            e = exp_q.pop_front();
            check("event_id_type", {28'd0, ev_id, ev_type}, {28'd0, e});
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_sw(input logic [N-1:0] v);
    @(posedge CLK);
    #2 sw_in = v;
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    sw_in = v;
    exp_q.delete();
    repeat (3) @(negedge CLK);
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_valid", {31'd0, ev_valid}, 32'd0);
    check("reset_ovf", {31'd0, ev_ovf}, 32'd0);
    @(posedge CLK);
    #2 RST_N = 1'b1;
  endtask

  // Counts negedges until state[idx] reads val (bounded).
  task automatic wait_state(input int idx, input logic val, output int cyc);
    cyc = 0;
    while (state[idx] !== val && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    check("state_settle", {31'd0, state[idx]}, {31'd0, val});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, v, lo, hi);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: each step changes one switch; expected event is that
  // button with its new level.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] sw;
    logic [1:0]   id;
    logic [1:0]   typ;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc;
    int n;
    int ovf_before;

    vecs[0] = '{sw: 4'b0100, id: 2'd2, typ: 2'b01};
    vecs[1] = '{sw: 4'b0110, id: 2'd1, typ: 2'b01};
    vecs[2] = '{sw: 4'b0010, id: 2'd2, typ: 2'b00};
    vecs[3] = '{sw: 4'b1010, id: 2'd3, typ: 2'b01};
    vecs[4] = '{sw: 4'b1000, id: 2'd1, typ: 2'b00};
    vecs[5] = '{sw: 4'b0000, id: 2'd3, typ: 2'b00};
    vecs[6] = '{sw: 4'b0001, id: 2'd0, typ: 2'b01};
    vecs[7] = '{sw: 4'b0000, id: 2'd0, typ: 2'b00};

    // Reset with all switches high: four presses drain in index order.
    do_reset(4'hF);
    for (int i = 0; i < N; i++) exp_q.push_back({2'(i), 2'b01});
    drain();
    check("reset_hold_state", {28'd0, state}, 32'hF);

    // Table-driven single-button changes with latency checks.
    do_reset(4'h0);
    for (int v = 0; v < 8; v++) begin
      @(posedge CLK);
      #2 sw_in = vecs[v].sw;
      exp_q.push_back({vecs[v].id, vecs[v].typ});
      wait_state(int'(vecs[v].id), vecs[v].sw[vecs[v].id], cyc);
      check_range("settle_cycles", cyc, 12, 15);
`ifndef BUTTON_EVENT_SCHEDULER_LONGPRESS_EN
      check("valid_not_same_edge", {31'd0, ev_valid}, 32'd0);
      @(negedge CLK);
      check("valid_next_edge", {31'd0, ev_valid}, 32'd1);
      check("ev_id", {30'd0, ev_id}, {30'd0, vecs[v].id});
      check("ev_type", {30'd0, ev_type}, {30'd0, vecs[v].typ});
      @(negedge CLK);
      check("valid_one_cycle", {31'd0, ev_valid}, 32'd0);
`endif
      repeat (3) @(negedge CLK);
      check("table_state", {28'd0, state}, {28'd0, vecs[v].sw});
    end
    drain();

    // Glitch reject: 6 cycles high covers at most two ticks.
    drive_sw(4'b0010);
    repeat (6) @(posedge CLK);
    #2 sw_in = 4'b0000;
    repeat (25) @(negedge CLK);
    check("glitch_state", {28'd0, state}, 32'd0);
    check("glitch_no_event", exp_q.size(), 32'd0);

    // Arbitration under back-pressure.
    do_reset(4'h0);
    ev_ready = 1'b0;
    drive_sw(4'b1011);
    exp_q.push_back({2'd0, 2'b01});
    exp_q.push_back({2'd1, 2'b01});
    exp_q.push_back({2'd3, 2'b01});
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ev_valid) check("stall_id", {30'd0, ev_id}, 32'd0);
    end
    check("stall_valid", {31'd0, ev_valid}, 32'd1);
    check("stall_type", {30'd0, ev_type}, 32'd1);
    @(posedge CLK);
    #2 ev_ready = 1'b1;
    @(negedge CLK);
    check("b2b_0_valid", {31'd0, ev_valid}, 32'd1);
    check("b2b_0_id", {30'd0, ev_id}, 32'd0);
    @(negedge CLK);
    check("b2b_1_valid", {31'd0, ev_valid}, 32'd1);
    check("b2b_1_id", {30'd0, ev_id}, 32'd1);
    @(negedge CLK);
    check("b2b_3_valid", {31'd0, ev_valid}, 32'd1);
    check("b2b_3_id", {30'd0, ev_id}, 32'd3);
    @(negedge CLK);
    check("b2b_after_valid", {31'd0, ev_valid}, 32'd0);
    drain();

    // Overwrite: button 1's press occupies the output register, so button 0's
    // press stays pending and is replaced by its release.
    do_reset(4'h0);
    ev_ready   = 1'b0;
    ovf_before = ovf_cnt;
    drive_sw(4'b0010);
    exp_q.push_back({2'd1, 2'b01});
    wait_state(1, 1'b1, cyc);
    drive_sw(4'b0011);
    wait_state(0, 1'b1, cyc);
    check("ovf_none_yet", ovf_cnt - ovf_before, 32'd0);
    drive_sw(4'b0010);
    wait_state(0, 1'b0, cyc);
    repeat (3) @(negedge CLK);
    check("ovf_once", ovf_cnt - ovf_before, 32'd1);
    check("ovf_hold_id", {30'd0, ev_id}, 32'd1);
    check("ovf_hold_valid", {31'd0, ev_valid}, 32'd1);
    exp_q.push_back({2'd0, 2'b00});
    @(posedge CLK);
    #2 ev_ready = 1'b1;
    drain();
    repeat (5) @(negedge CLK);

    // Asynchronous reset while an event is presented.
    do_reset(4'h0);
    ev_ready = 1'b0;
    drive_sw(4'b0100);
    exp_q.push_back({2'd2, 2'b01});
    wait_state(2, 1'b1, cyc);
    @(negedge CLK);
    check("pre_async_valid", {31'd0, ev_valid}, 32'd1);
    #2 RST_N = 1'b0;
    exp_q.delete();
    #1;
    check("async_valid", {31'd0, ev_valid}, 32'd0);
    check("async_state", {28'd0, state}, 32'd0);
    @(posedge CLK);
    #2;
    RST_N    = 1'b1;
    ev_ready = 1'b1;
    exp_q.push_back({2'd2, 2'b01});
    drain();

`ifdef BUTTON_EVENT_SCHEDULER_LONGPRESS_EN
    // Long press on button 3: press, exactly one long press, release.
    do_reset(4'h0);
    long_mode = 1'b1;
    drive_sw(4'b1000);
    exp_q.push_back({2'd3, 2'b01});
    exp_q.push_back({2'd3, 2'b10});
    wait_state(3, 1'b1, cyc);
    n = 0;
    while (!(ev_valid && ev_type == 2'b10) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check("long_latency", n, 32'd21);
    repeat (40) @(negedge CLK);
    drive_sw(4'b0000);
    exp_q.push_back({2'd3, 2'b00});
    wait_state(3, 1'b0, cyc);
    drain();
    long_mode = 1'b0;
`endif

    check("total_ovf", ovf_cnt, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
